// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter (ALU vs. load data) feeding a single register-file write port,
// with a per-register pending-write scoreboard. Define WB_STATS_EN to add conflict/writeback counters.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_addr,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
`ifdef WB_STATS_EN
  output logic [15:0]          conflict_cnt,
  output logic [15:0]          wb_cnt,
`endif
  output logic [2**ADDR_W-1:0] busy
);

  // Handshake: a requester transfers in a cycle where its valid and ready are both high.
  // Ready is a pure function of both valids, rst and last_mem; a requester that is
  // not granted must hold addr/data stable, nothing is buffered here.
  localparam int NREG = 2**ADDR_W;

  logic              last_mem;
  logic              conflict;
  logic              wb_fire;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NREG-1:0]   busy_next;

  assign conflict = alu_valid & mem_valid;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (conflict) begin
        alu_ready = last_mem;
        mem_ready = ~last_mem;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign wb_fire  = alu_ready | mem_ready;
  assign wb_addr  = mem_ready ? mem_addr : alu_addr;
  assign wb_data  = mem_ready ? mem_data : alu_data;
  // Register 0 is hardwired: accepted but never written.
  assign wb_write = wb_fire && (wb_addr != '0);

  // Clear first, then set, so a same-cycle reservation of the written register survives.
  always_comb begin
    busy_next = busy;
    if (wb_write) busy_next[wb_addr] = 1'b0;
    if (issue_valid && (issue_addr != '0)) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
      last_mem <= 1'b1;
    end else begin
      rf_we <= wb_write;
      if (wb_write) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
      busy <= busy_next;
      if (conflict) last_mem <= mem_ready;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      wb_cnt       <= '0;
    end else begin
      if (conflict && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
      if (rf_we && (wb_cnt != 16'hFFFF)) wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed steps then randomized traffic, all checked against
// a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [AW-1:0] alu_addr, mem_addr, issue_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] busy;
`ifdef WB_STATS_EN
  logic [15:0]   conflict_cnt, wb_cnt;
`endif

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_STATS_EN
    .conflict_cnt(conflict_cnt), .wb_cnt(wb_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state
  bit          m_alu_wins_next;
  bit [NR-1:0] m_busy;
  bit          m_we;
  bit [AW-1:0] m_waddr;
  bit [DW-1:0] m_wdata;
  int          m_conf, m_wb;
  bit          lg_a, lg_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_grant(output bit ga, output bit gm);
    ga = 1'b0;
    gm = 1'b0;
    if (rst) return;
    if (alu_valid && mem_valid) begin
      if (m_alu_wins_next) ga = 1'b1;
      else gm = 1'b1;
    end else begin
      ga = alu_valid;
      gm = mem_valid;
    end
  endfunction

  // Inputs are driven just after a falling edge; this checks ready, clocks once, and checks registered outputs.
  task automatic cycle();
    bit ga, gm;
    int dst;
    #1;
    model_grant(ga, gm);
    lg_a = ga;
    lg_m = gm;
    chk("alu_ready", alu_ready, ga);
    chk("mem_ready", mem_ready, gm);
    @(posedge clk);
    if (rst) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_busy = '0;
      m_alu_wins_next = 1; m_conf = 0; m_wb = 0;
    end else begin
      if (alu_valid && mem_valid) begin
        m_conf = (m_conf < 65535) ? m_conf + 1 : 65535;
        m_alu_wins_next = gm;
      end
      if (m_we) m_wb = (m_wb < 65535) ? m_wb + 1 : 65535;
      dst = gm ? int'(mem_addr) : int'(alu_addr);
      m_we = (ga || gm) && (dst != 0);
      if (m_we) begin
        m_waddr = AW'(dst);
        m_wdata = gm ? mem_data : alu_data;
        m_busy[dst] = 1'b0;
      end
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("busy", busy, m_busy);
`ifdef WB_STATS_EN
    chk("conflict_cnt", conflict_cnt, 64'(m_conf));
    chk("wb_cnt", wb_cnt, 64'(m_wb));
`endif
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask

  initial begin
    logic [AW-1:0] seq [4];
    rst = 1; idle_inputs();
    alu_addr = '0; mem_addr = '0; issue_addr = '0; alu_data = '0; mem_data = '0;
    m_alu_wins_next = 1; m_busy = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_conf = 0; m_wb = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("reset_busy", busy, 0);
    chk("reset_we", rf_we, 0);

    // Single ALU writeback with latency 1
    rst = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 32'h0000_0032;
    cycle();
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 3);
    chk("single_wdata", rf_wdata, 32'h0000_0032);

    // Round-robin under sustained conflict
    alu_addr = 5; alu_data = 32'hA5; mem_valid = 1; mem_addr = 6; mem_data = 32'hB6;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq[i] = rf_waddr;
    end
    chk("rr_0", seq[0], 5);
    chk("rr_1", seq[1], 6);
    chk("rr_2", seq[2], 5);
    chk("rr_3", seq[3], 6);
    idle_inputs();

    // Register 0 write is accepted but suppressed
    mem_valid = 1; mem_addr = 0; mem_data = 32'hDEAD_BEEF;
    #1 chk("r0_mem_ready", mem_ready, 1);
    cycle();
    chk("r0_we", rf_we, 0);
    idle_inputs();

    // Scoreboard set, set-wins-over-clear, then clear
    issue_valid = 1; issue_addr = 7;
    cycle();
    chk("busy7_set", busy[7], 1);
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    cycle();
    chk("busy7_setwins", busy[7], 1);
    issue_valid = 0;
    cycle();
    chk("busy7_clear", busy[7], 0);
    idle_inputs();

    // Reset right after an ALU grant
    issue_valid = 1; issue_addr = 9;
    cycle();
    issue_valid = 0; alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    cycle();
    alu_valid = 0; rst = 1;
    cycle();
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    alu_valid = 1; alu_addr = 11; alu_data = 32'h11; mem_valid = 1; mem_addr = 12; mem_data = 32'h12;
    cycle();
    chk("post_rst_alu_wins", rf_waddr, 11);
    idle_inputs();

`ifdef WB_STATS_EN
    rst = 1; cycle(); rst = 0;
    alu_valid = 1; mem_valid = 1; alu_addr = 1; mem_addr = 2;
    for (int i = 0; i < 3; i++) cycle();
    mem_valid = 0;
    cycle(); cycle();
    alu_valid = 0;
    cycle();
    chk("stats_conflict", conflict_cnt, 3);
    chk("stats_wb", wb_cnt, 5);
`endif

    // Randomized traffic; ungranted requesters hold their request
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!(alu_valid && !lg_a)) begin
        alu_valid = $urandom_range(0, 1);
        alu_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR-1));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !lg_m)) begin
        mem_valid = $urandom_range(0, 1);
        mem_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR-1));
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_addr  = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_addr  in  ADDR_W  ALU destination register.
REQ-007 alu_data  in  DATA_W  ALU result.
REQ-008 alu_ready  out  1  ALU request accepted this cycle (combinational).
REQ-009 mem_valid  in  1  load-data writeback request.
REQ-010 mem_addr  in  ADDR_W  load destination register.
REQ-011 mem_data  in  DATA_W  load data.
REQ-012 mem_ready  out  1  load request accepted this cycle (combinational).
REQ-013 issue_valid  in  1  issue stage reserves a destination register.
REQ-014 issue_addr  in  ADDR_W  register being reserved.
REQ-015 rf_we  out  1  register-file write enable (registered).
REQ-016 rf_waddr  out  ADDR_W  register-file write address (registered).
REQ-017 rf_wdata  out  DATA_W  register-file write data (registered).
REQ-018 busy  out  2**ADDR_W  per-register pending-write scoreboard (registered).

Function
REQ-019 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high.
REQ-020 SHALL set ready only for the granted requester; ready SHALL NOT depend on the other requester's ready.
REQ-021 One requester valid: SHALL grant it.
REQ-022 Both valid: SHALL grant the requester not granted in the most recent conflict cycle (round-robin flag last_mem; 1 = memory won last conflict).
REQ-023 last_mem SHALL update only in cycles where both are valid; single-requester grants leave it unchanged.
REQ-024 Next cycle after a transfer: rf_we=1, rf_waddr/rf_wdata = granted request's addr/data (latency 1); otherwise rf_we=0, rf_waddr/rf_wdata hold.
REQ-025 Transfer to address 0: SHALL be accepted (ready=1) but rf_we SHALL stay 0 next cycle.
REQ-026 issue_valid with issue_addr!=0 SHALL set busy[issue_addr] next cycle.
REQ-027 Transfer to address A!=0 SHALL clear busy[A] next cycle.
REQ-028 Same-cycle set and clear of the same register: set wins (busy stays 1).
REQ-029 busy[0] SHALL always read 0.
REQ-030 Requester holding valid while not granted SHALL keep addr/data stable; block SHALL not buffer ungranted requests.

Reset
REQ-031 While rst=1 at a rising edge: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, last_mem=1 (ALU wins first conflict), stats counters=0.
REQ-032 While rst=1, alu_ready and mem_ready SHALL be 0; no transfer occurs.
REQ-033 Reset mid-operation SHALL drop any granted-but-unwritten request; rf_we=0 in the cycle after reset.

Configuration
REQ-034 Macro WB_STATS_EN defined: SHALL add outputs conflict_cnt (16) and wb_cnt (16); conflict_cnt increments on each both-valid cycle, wb_cnt on each rf_we=1 cycle; both saturate at 16'hFFFF.
REQ-035 WB_STATS_EN undefined: counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-036 After reset, alu_valid=1, alu_addr=3, alu_data=32'h0000_0032 -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=32'h0000_0032.
REQ-037 Both valid for 4 cycles (alu addr 5, mem addr 6) -> grants ALU, MEM, ALU, MEM; rf_waddr sequence 5,6,5,6.
REQ-038 mem_valid=1, mem_addr=0, mem_data=32'hDEAD_BEEF -> mem_ready=1; rf_we stays 0.
REQ-039 issue_valid addr 7 in cycle N -> busy[7]=1 from N+1; cycle M both issue addr 7 and ALU writeback addr 7 -> busy[7] remains 1.
REQ-040 rst pulsed in the cycle after an ALU grant -> rf_we=0, busy=0; next conflict granted to ALU.
REQ-041 With WB_STATS_EN, 3 conflict cycles then 2 single writes -> conflict_cnt=3, wb_cnt=5.
